rf_exec: RTL

Execution datapath that responds to the register-file test sequencer. It accepts per-cycle command triples (read address A, read address B, write address) and performs array[W] = array[A] + array[B] on a 32-entry register array. Every written value is folded into a running MISR signature. When the sequencer signals done, the block drains its pipeline and reports pass/fail against an expected signature.

---
 rtl/rf_exec_pkg.sv | 31 +++
 rtl/rf_exec_array.sv | 35 +++
 rtl/rf_exec.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rf_exec_pkg.sv
// rf_exec_pkg: shared types, array geometry and the MISR step for rf_exec.
// Configuration macro used by rf_exec: RF_EXEC_FWD_EN.
package rf_exec_pkg;

  localparam int RF_DEPTH   = 32;
  localparam int RF_AW      = 5;
  localparam int MISR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_e;

  // One MISR step: rotate-left-by-one of s within w bits, then xor d.
  // Operands are carried zero-extended in a 64-bit container so one function
  // serves any signature width up to MISR_MAX_W.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] s,
    input logic [MISR_MAX_W-1:0] d,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] rot;
    mask = (w >= MISR_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    rot  = ((s << 1) | ((s >> (w - 1)) & 64'd1)) & mask;
    return (rot ^ d) & mask;
  endfunction

endpackage

// File: rtl/rf_exec_array.sv
// rf_array: 32 x WIDTH register array, two combinational read ports and one
// synchronous write port. Reset loads each entry with its own index.
module rf_array
  import rf_exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RF_AW-1:0] rd_addr_a,
  input  logic [RF_AW-1:0] rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             wr_vld,
  input  logic [RF_AW-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [RF_DEPTH];

  // Storage: index pattern on reset, single write port otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        mem[i] <= WIDTH'(i);
      end
    end else if (wr_vld) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/rf_exec.sv
// rf_exec: executes array[W] = array[A] + array[B] for each command triple
// from the register-file test sequencer, folds every written value into a
// MISR, and reports pass/fail against exp_sig after done.
// Optional macro RF_EXEC_FWD_EN: forward the stage-2 sum into the stage-1
// read ports on a distance-1 hazard. Undefined: hazard reads the old value.
//
// state  | meaning
// IDLE   | waiting for the first command of a run
// RUN    | accepting commands, watching seq_error, waiting for done
// DRAIN  | one cycle to retire the last in-flight op
// REPORT | compare signature, launch result pulse
module rf_exec
  import rf_exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_vld,
  input  logic [RF_AW-1:0] rd_enA,
  input  logic [RF_AW-1:0] rd_enB,
  input  logic [RF_AW-1:0] wr_en,
  input  logic             done,
  input  logic             seq_error,
  input  logic [WIDTH-1:0] exp_sig,
  output logic [WIDTH-1:0] sig,
  output logic             busy,
  output logic             result_vld,
  output logic             pass,
  output logic             fail
);

  state_e state, state_nxt;

  logic             accept;
  logic             start;
  logic             err_set;
  logic             report;
  logic             err_sticky;
  logic             pass_n;

  logic             v1;
  logic [WIDTH-1:0] a1, b1;
  logic [RF_AW-1:0] w1;
  logic [WIDTH-1:0] sum;

  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] opa, opb;

  rf_array #(.WIDTH(WIDTH)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_enA),
    .rd_addr_b (rd_enB),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b),
    .wr_vld    (v1),
    .wr_addr   (w1),
    .wr_data   (sum)
  );

  assign sum = a1 + b1;

`ifdef RF_EXEC_FWD_EN
  assign opa = (v1 && (rd_enA == w1)) ? sum : rd_a;
  assign opb = (v1 && (rd_enB == w1)) ? sum : rd_b;
`else
  assign opa = rd_a;
  assign opb = rd_b;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    start     = 1'b0;
    err_set   = 1'b0;
    report    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_vld) begin
          accept    = 1'b1;
          start     = 1'b1;
          state_nxt = done ? DRAIN : RUN;
        end
      end
      RUN: begin
        accept  = cmd_vld;
        err_set = seq_error;
        if (done) state_nxt = DRAIN;
      end
      DRAIN: begin
        err_set   = cmd_vld;
        state_nxt = REPORT;
      end
      REPORT: begin
        err_set   = cmd_vld;
        report    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pass_n = (sig == exp_sig) && !err_sticky;
  assign busy   = (state != IDLE);

  // Stage-1 pipeline register: operands and write address of the accepted op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      w1 <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1 <= opa;
        b1 <= opb;
        w1 <= wr_en;
      end
    end
  end

  // Signature: cleared at run start, stepped by each retiring write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sig <= '0;
    else if (start) sig <= '0;
    else if (v1)    sig <= WIDTH'(misr_step(64'(sig), 64'(sum), WIDTH));
  end

  // Sticky error collected over a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_sticky <= 1'b0;
    else if (start)   err_sticky <= 1'b0;
    else if (err_set) err_sticky <= 1'b1;
  end

  // Result pulse and held verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_vld <= 1'b0;
      pass       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      result_vld <= report;
      if (report) begin
        pass <= pass_n;
        fail <= !pass_n;
      end else if (start) begin
        pass <= 1'b0;
        fail <= 1'b0;
      end
    end
  end

endmodule
